eespfal_phase_sequencer: RTL



---
 rtl/eespfal_pkg.sv | 17 +
 rtl/eespfal_phase_timer.sv | 53 +++++
 rtl/eespfal_phase_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/eespfal_pkg.sv
// Shared types and default sizing for the EESPFAL lane phase sequencer.
package eespfal_pkg;

    localparam int DEF_BIT_SIZE = 64;
    localparam int DEF_PHASES   = 4;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        LAUNCH,
        EVAL,
        CAPTURE,
        DONE
    } state_e;

endpackage

// File: rtl/eespfal_phase_timer.sv
// Step timer: reloadable (H-1)..0 down-counter that advances a phase index on wrap.
module eespfal_phase_timer
    import eespfal_pkg::*;
#(
    parameter int PHASES = DEF_PHASES,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int IDX_W = $clog2(PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [IDX_W-1:0] phase_idx,
    output logic             step_done,
    output logic             last_step
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign step_done = en && (cnt_q == '0);
    assign last_step = (idx_q == IDX_W'(PHASES - 1));
    assign phase_idx = idx_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (load) begin
            cnt_d = load_val;
            idx_d = '0;
        end else if (step_done) begin
            cnt_d = load_val;
            // Index parks on the last step; the FSM leaves on that step's wrap.
            if (!last_step) idx_d = idx_q + IDX_W'(1);
        end else if (en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/eespfal_phase_sequencer.sv
// Drives one EESPFAL dual-rail lane: discharge, overlapping power-clock phases,
// dual-rail operand launch and result capture with rail-error detection.
module eespfal_phase_sequencer
    import eespfal_pkg::*;
#(
    parameter int BIT_SIZE = DEF_BIT_SIZE,
    parameter int PHASES   = DEF_PHASES,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    input  logic [BIT_SIZE-1:0] x_in,
    input  logic [BIT_SIZE-1:0] k_in,
    input  logic [CNT_W-1:0]    hold_cycles,
    input  logic                dis_mode,
    output logic [PHASES-1:0]   clk_ph,
    output logic [PHASES-1:0]   dis_ph,
    output logic                dis_phase,
    output logic [BIT_SIZE-1:0] x,
    output logic [BIT_SIZE-1:0] x_bar,
    output logic [BIT_SIZE-1:0] k,
    output logic [BIT_SIZE-1:0] k_bar,
    input  logic [BIT_SIZE-1:0] s_in,
    input  logic [BIT_SIZE-1:0] s_bar_in,
    output logic [BIT_SIZE-1:0] result,
    output logic                result_valid,
    output logic                rail_err
);

    localparam int IDX_W = $clog2(PHASES);

    state_e              state_q, state_d;
    logic [BIT_SIZE-1:0] x_l_q, x_l_d, k_l_q, k_l_d;
    logic [BIT_SIZE-1:0] result_q, result_d;
    logic                rail_err_q, rail_err_d;
    logic [CNT_W-1:0]    h_m1_q, h_m1_d, h_m1_in, timer_val;
    logic                timer_load, timer_en, step_done, last_step, rails_on;
    logic [IDX_W-1:0]    phase_idx;

    // hold_cycles == 0 behaves as a one-cycle step.
    assign h_m1_in   = (hold_cycles == '0) ? '0 : hold_cycles - CNT_W'(1);
    assign timer_val = (state_q == IDLE) ? h_m1_in : h_m1_q;

    eespfal_phase_timer #(
        .PHASES (PHASES),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .en        (timer_en),
        .load_val  (timer_val),
        .phase_idx (phase_idx),
        .step_done (step_done),
        .last_step (last_step)
    );

    always_comb begin
        state_d    = state_q;
        x_l_d      = x_l_q;
        k_l_d      = k_l_q;
        h_m1_d     = h_m1_q;
        result_d   = result_q;
        rail_err_d = rail_err_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_load = 1'b1;
                if (start) begin
                    x_l_d   = x_in;
                    k_l_d   = k_in;
                    h_m1_d  = h_m1_in;
                    state_d = dis_mode ? DISCHARGE : LAUNCH;
                end
            end
            DISCHARGE: begin
                timer_en = 1'b1;
                if (step_done) state_d = LAUNCH;
            end
            LAUNCH: begin
                timer_load = 1'b1;
                state_d    = EVAL;
            end
            EVAL: begin
                timer_en = 1'b1;
                if (step_done && last_step) state_d = CAPTURE;
            end
            CAPTURE: begin
                result_d   = s_in;
                rail_err_d = |(~(s_in ^ s_bar_in));
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready        = 1'b0;
        clk_ph       = '0;
        dis_ph       = '1;
        dis_phase    = 1'b0;
        result_valid = 1'b0;
        rails_on     = 1'b0;
        unique case (state_q)
            IDLE:      ready = 1'b1;
            DISCHARGE: dis_phase = 1'b1;
            LAUNCH: begin
                rails_on = 1'b1;
                dis_ph   = '0;
            end
            EVAL: begin
                rails_on = 1'b1;
                // Current phase plus the previous one, so adjacent phases overlap.
                for (int i = 0; i < PHASES; i++) begin
                    clk_ph[i] = (int'(phase_idx) == i) || (int'(phase_idx) == i + 1);
                end
                dis_ph = ~clk_ph;
            end
            CAPTURE: begin
                rails_on           = 1'b1;
                clk_ph[PHASES-1]   = 1'b1;
                dis_ph             = ~clk_ph;
            end
            DONE:    result_valid = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Outside an operation the lane sees the null spacer (both rails low).
    assign x        = rails_on ? x_l_q  : '0;
    assign x_bar    = rails_on ? ~x_l_q : '0;
    assign k        = rails_on ? k_l_q  : '0;
    assign k_bar    = rails_on ? ~k_l_q : '0;
    assign result   = result_q;
    assign rail_err = rail_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_l_q      <= '0;
            k_l_q      <= '0;
            h_m1_q     <= '0;
            result_q   <= '0;
            rail_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_l_q      <= x_l_d;
            k_l_q      <= k_l_d;
            h_m1_q     <= h_m1_d;
            result_q   <= result_d;
            rail_err_q <= rail_err_d;
        end
    end

endmodule
